multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset controller: Moore FSM sequencing fetch/decode/execute with a sticky illegal-opcode trap.
// Optional U-type (LUI/AUIPC) sequencing is compiled in when RV_UTYPE_EN is defined.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] Op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrcD,
   output logic       IllegalInst
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

`ifdef RV_UTYPE_EN
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BEQ, JAL, UPPER, TRAP
   } state_t;
`else
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
   } state_t;
`endif

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   pc_write, adr_src, mem_write, ir_write, reg_write;

   // Subtract only for R-type (Op[5]=1) with funct7b5 set; I-type never subtracts.
   function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic f7b5, input logic op5);
      case (f3)
         3'b000:  return (f7b5 && op5) ? ALU_SUB : ALU_ADD;
         3'b010:  return ALU_SLT;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    state_d = DECODE;
         DECODE: begin
            case (Op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_R:              state_d = EXECR;
               OP_I:              state_d = EXECI;
               OP_BR:             state_d = BEQ;
               OP_JAL:            state_d = JAL;
`ifdef RV_UTYPE_EN
               OP_LUI, OP_AUIPC:  state_d = UPPER;
`endif
               default:           state_d = TRAP;
            endcase
         end
         MEMADR:   state_d = (Op == OP_STORE) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_d = MEMWB;
         EXECR, EXECI, JAL: state_d = ALUWB;
`ifdef RV_UTYPE_EN
         UPPER:    state_d = ALUWB;
`endif
         MEMWB, MEMWRITE, ALUWB, BEQ: state_d = FETCH;
         TRAP:     state_d = TRAP;
         default:  state_d = FETCH;
      endcase
      illegal_d = illegal_q | (state_d == TRAP);
   end

   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      case (state_q)
         FETCH: begin
            ir_write  = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            pc_write  = 1'b1;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         MEMREAD:  adr_src = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = funct_alu(funct3, funct7b5, Op[5]);
         end
         EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = funct_alu(funct3, funct7b5, Op[5]);
         end
         ALUWB:    reg_write = 1'b1;
         BEQ: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            pc_write   = Zero;
         end
         JAL: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pc_write = 1'b1;
         end
`ifdef RV_UTYPE_EN
         // LUI adds the immediate to a forced zero operand; AUIPC adds it to the old PC.
         UPPER: begin
            ALUSrcA = (Op == OP_LUI) ? 2'b11 : 2'b01;
            ALUSrcB = 2'b01;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      case (Op)
         OP_LOAD, OP_I, OP_JALR: ImmSrcD = 3'b000;
         OP_STORE:               ImmSrcD = 3'b001;
         OP_BR:                  ImmSrcD = 3'b010;
         OP_JAL:                 ImmSrcD = 3'b011;
`ifdef RV_UTYPE_EN
         OP_LUI, OP_AUIPC:       ImmSrcD = 3'b100;
`endif
         default:                ImmSrcD = 3'b000;
      endcase
   end

   // Strobes are gated by reset so an interrupted write cannot leave a partial pulse.
   assign PCWrite     = pc_write  & ~reset;
   assign IRWrite     = ir_write  & ~reset;
   assign MemWrite    = mem_write & ~reset;
   assign RegWrite    = reg_write & ~reset;
   assign AdrSrc      = adr_src;
   assign IllegalInst = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction expected output sequences built from the opcode class.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] Op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInst;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl, ImmSrcD;
   logic [17:0] obs;

   int n_chk = 0;
   int n_bad = 0;
   logic [14:0] plan_q[$];
   logic [6:0]  ops[8] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI, OP_AUIPC};

   multicycle_controller dut (
      .clk(clk), .reset(reset), .Op(Op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .ImmSrcD(ImmSrcD), .IllegalInst(IllegalInst)
   );

   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, ImmSrcD, IllegalInst};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] mk(input bit pcw, input bit adr, input bit mw, input bit irw, input bit rw,
                                      input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, alu};
   endfunction

   function automatic logic [2:0] imm_exp(input logic [6:0] op);
      if (op == OP_STORE) return 3'b001;
      if (op == OP_BR)    return 3'b010;
      if (op == OP_JAL)   return 3'b011;
`ifdef RV_UTYPE_EN
      if (op == OP_LUI || op == OP_AUIPC) return 3'b100;
`endif
      return 3'b000;
   endfunction

   function automatic logic [2:0] alu_exp(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      if (f3 == 3'd0) return (f7 && op == OP_R) ? 3'b001 : 3'b000;
      if (f3 == 3'd2) return 3'b101;
      if (f3 == 3'd6) return 3'b011;
      if (f3 == 3'd7) return 3'b010;
      return 3'b000;
   endfunction

   // Expected per-cycle outputs for one instruction, starting at its fetch cycle.
   task automatic build_plan(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
      logic [14:0] wb;
      wb = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
      plan_q = {};
      plan_q.push_back(mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000));
      plan_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000));
      case (op)
         OP_LOAD: begin
            plan_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000));
            plan_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
            plan_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000));
         end
         OP_STORE: begin
            plan_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000));
            plan_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
         end
         OP_R: begin
            plan_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_exp(op, f3, f7)));
            plan_q.push_back(wb);
         end
         OP_I: begin
            plan_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_exp(op, f3, f7)));
            plan_q.push_back(wb);
         end
         OP_BR: plan_q.push_back(mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001));
         OP_JAL: begin
            plan_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000));
            plan_q.push_back(wb);
         end
`ifdef RV_UTYPE_EN
         OP_LUI, OP_AUIPC: begin
            plan_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, (op == OP_LUI) ? 2'b11 : 2'b01, 2'b01, 3'b000));
            plan_q.push_back(wb);
         end
`endif
         default: ;
      endcase
   endtask

   // Entered just after a falling edge with the DUT in FETCH; returns at the falling edge of the next FETCH.
   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z);
      Op = op; funct3 = f3; funct7b5 = f7; Zero = z;
      build_plan(op, f3, f7, z);
      foreach (plan_q[k]) begin
         #1 check($sformatf("%s_op%07b_c%0d", name, op, k), obs, {plan_q[k], imm_exp(op), 1'b0});
         @(negedge clk);
      end
   endtask

   task automatic trap_seq(input string name, input logic [6:0] op, input int hold);
      Op = op; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b1;
      build_plan(op, 3'd0, 1'b0, 1'b1);
      foreach (plan_q[k]) begin
         #1 check($sformatf("%s_c%0d", name, k), obs, {plan_q[k], imm_exp(op), 1'b0});
         @(negedge clk);
      end
      for (int i = 0; i < hold; i++) begin
         #1 check($sformatf("%s_trap%0d", name, i), obs, {15'd0, imm_exp(op), 1'b1});
         @(negedge clk);
      end
      reset = 1'b1;
      #1 check({name, "_rst_clear"}, obs, {mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000), imm_exp(op), 1'b0});
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int nops;
`ifdef RV_UTYPE_EN
      nops = 8;
`else
      nops = 6;
`endif
      repeat (2) @(negedge clk);
      #1 check("reset_state", obs, {mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000), 3'b000, 1'b0});
      @(negedge clk);
      reset = 1'b0;

      run_instr("load", OP_LOAD, 3'd2, 1'b0, 1'b0);
      run_instr("beq_taken", OP_BR, 3'd0, 1'b0, 1'b1);
      run_instr("beq_not", OP_BR, 3'd0, 1'b0, 1'b0);
      run_instr("r_sub", OP_R, 3'd0, 1'b1, 1'b0);
      run_instr("i_add", OP_I, 3'd0, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [6:0] op;
         op = ops[$urandom_range(0, nops - 1)];
         run_instr($sformatf("rnd%0d", n), op, 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Store interrupted by reset while MemWrite is high, between clock edges.
      Op = OP_STORE; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
      build_plan(OP_STORE, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1 check($sformatf("st_c%0d", k), obs, {plan_q[k], 3'b001, 1'b0});
         @(negedge clk);
      end
      #1 check("st_memwrite_on", obs, {plan_q[3], 3'b001, 1'b0});
      #1 reset = 1'b1;
      #1 check("st_async_rst", obs, {mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000), 3'b001, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      run_instr("after_rst", OP_LOAD, 3'd0, 1'b0, 1'b0);

`ifdef RV_UTYPE_EN
      run_instr("lui", OP_LUI, 3'd0, 1'b0, 1'b0);
      run_instr("auipc", OP_AUIPC, 3'd0, 1'b0, 1'b0);
`else
      trap_seq("lui_trap", OP_LUI, 3);
`endif
      trap_seq("illegal", OP_BAD, 12);
      run_instr("post_trap", OP_JAL, 3'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
